// File: rtl/armleocpu_scoreboard_if.sv
// Decode/execute/writeback handshake bundle for the register scoreboard.
//   master : pipeline side (drives decode fields, exe_ready, flush,
//            writeback, drain_req; observes issue/stall/drain/status)
//   slave  : scoreboard side
interface armleocpu_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             dec_valid;
  logic             dec_rs1_read;
  logic [4:0]       dec_rs1_addr;
  logic             dec_rs2_read;
  logic [4:0]       dec_rs2_addr;
  logic             dec_rd_write;
  logic [4:0]       dec_rd_addr;
  logic             dec_long;
  logic             exe_ready;
  logic             flush;
  logic             issue_valid;
  logic             dec_stall;
  logic             wb_valid;
  logic [4:0]       wb_rd_addr;
  logic             drain_req;
  logic             drain_ack;
  logic [CNT_W-1:0] pending_count;
  logic             sb_error;

  modport master (
    output dec_valid, dec_rs1_read, dec_rs1_addr, dec_rs2_read, dec_rs2_addr,
           dec_rd_write, dec_rd_addr, dec_long, exe_ready, flush,
           wb_valid, wb_rd_addr, drain_req,
    input  issue_valid, dec_stall, drain_ack, pending_count, sb_error
  );

  modport slave (
    input  dec_valid, dec_rs1_read, dec_rs1_addr, dec_rs2_read, dec_rs2_addr,
           dec_rd_write, dec_rd_addr, dec_long, exe_ready, flush,
           wb_valid, wb_rd_addr, drain_req,
    output issue_valid, dec_stall, drain_ack, pending_count, sb_error
  );
endinterface

// File: rtl/armleocpu_scoreboard.sv
// Register-hazard interlock between decode and execute.
// Tracks rd of issued long-latency ops until writeback, blocks issue on
// RAW/WAW hazards and on the outstanding-op limit, and offers a drain
// handshake for fences/serializing instructions.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   sb         : slave side of armleocpu_scoreboard_if (decode fields,
//                exe_ready, flush, writeback, drain, status outputs)
module armleocpu_scoreboard #(
  parameter int MAX_PENDING = 2,
  parameter int CNT_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  armleocpu_scoreboard_if.slave  sb
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PENDING);

  logic [31:0]      busy, busy_nxt, clr_mask, hit_mask, set_mask, eff_busy;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_eff;
  logic [0:0]       state;
  logic             wb_hit, wb_bad, hazard, limit, issue, fire, set_en;
  logic             ovf, unf, drain_ack_q, err_q;

  always_comb begin
    clr_mask = sb.wb_valid ? (32'd1 << sb.wb_rd_addr) : 32'd0;
    // Same-cycle writeback resolves the hazard (write-through regfile).
    eff_busy = busy & ~clr_mask;
    wb_hit   = sb.wb_valid & busy[sb.wb_rd_addr];
    wb_bad   = sb.wb_valid & ~busy[sb.wb_rd_addr];
    hazard   = (sb.dec_rs1_read & (sb.dec_rs1_addr != 5'd0) & eff_busy[sb.dec_rs1_addr])
             | (sb.dec_rs2_read & (sb.dec_rs2_addr != 5'd0) & eff_busy[sb.dec_rs2_addr])
             | (sb.dec_rd_write & (sb.dec_rd_addr  != 5'd0) & eff_busy[sb.dec_rd_addr]);
    cnt_eff  = cnt - {{(CNT_W-1){1'b0}}, wb_hit};
    limit    = sb.dec_long & (cnt_eff == MAXC);
    issue    = sb.dec_valid & ~hazard & ~limit & ~sb.flush & (state == RUN);
    fire     = issue & sb.exe_ready;
    set_en   = fire & sb.dec_long & sb.dec_rd_write & (sb.dec_rd_addr != 5'd0);
    set_mask = set_en ? (32'd1 << sb.dec_rd_addr) : 32'd0;
    hit_mask = wb_hit ? clr_mask : 32'd0;
    // Set is OR'd after the clear so a same-register collision keeps the bit.
    busy_nxt = ((busy & ~hit_mask) | set_mask) & ~32'd1;
    ovf      = set_en & ~wb_hit & (cnt == MAXC);
    unf      = wb_hit & ~set_en & (cnt == '0);
    cnt_nxt  = cnt;
    if (set_en & ~wb_hit)      cnt_nxt = cnt + 1'b1;
    else if (wb_hit & ~set_en) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      cnt         <= '0;
      state       <= RUN;
      drain_ack_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      cnt         <= cnt_nxt;
      drain_ack_q <= 1'b0;
      if (wb_bad | ovf | unf) err_q <= 1'b1;
      case (state)
        RUN: if (sb.drain_req) begin
          if (cnt == '0) drain_ack_q <= 1'b1;
          else           state       <= DRAIN;
        end
        default: if (cnt_nxt == '0) begin
          drain_ack_q <= 1'b1;
          state       <= RUN;
        end
      endcase
    end
  end

  assign sb.issue_valid   = issue;
  assign sb.dec_stall     = sb.dec_valid & ~issue & ~sb.flush;
  assign sb.drain_ack     = drain_ack_q;
  assign sb.pending_count = cnt;
  assign sb.sb_error      = err_q;
endmodule

// File: tb/tb_armleocpu_scoreboard.sv
// Directed scoreboard bench: each cycle's expected outputs are queued when
// the stimulus is driven and compared once the DUT has clocked.
module tb_armleocpu_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  armleocpu_scoreboard_if #(.CNT_W(3)) sb_if ();
  armleocpu_scoreboard #(.MAX_PENDING(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sb(sb_if)
  );

  typedef struct {
    string tag;
    logic  ei, es, ea, er;
    int    ec;
    logic  oi, os;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] ad, input logic w, input logic lg);
    sb_if.dec_valid    = v;
    sb_if.dec_rs1_read = 1'b1;
    sb_if.dec_rs1_addr = a1;
    sb_if.dec_rs2_read = 1'b1;
    sb_if.dec_rs2_addr = a2;
    sb_if.dec_rd_write = w;
    sb_if.dec_rd_addr  = ad;
    sb_if.dec_long     = lg;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    sb_if.wb_valid   = v;
    sb_if.wb_rd_addr = a;
  endtask

  // Inputs are already applied at the falling edge when this is called.
  task automatic cyc(input string tag, input logic ei, input logic es,
                     input int ec, input logic ea, input logic er);
    exp_t e;
    #1;
    e.tag = tag; e.ei = ei; e.es = es; e.ec = ec; e.ea = ea; e.er = er;
    e.oi = sb_if.issue_valid; e.os = sb_if.dec_stall;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check({e.tag, ".issue"}, 32'(e.oi), 32'(e.ei));
    check({e.tag, ".stall"}, 32'(e.os), 32'(e.es));
    check({e.tag, ".cnt"},   32'(sb_if.pending_count), 32'(e.ec));
    check({e.tag, ".ack"},   32'(sb_if.drain_ack), 32'(e.ea));
    check({e.tag, ".err"},   32'(sb_if.sb_error), 32'(e.er));
    @(negedge clk);
  endtask

  initial begin
    dec(0, 0, 0, 0, 0, 0); wb(0, 0);
    sb_if.exe_ready = 1'b1; sb_if.flush = 1'b0; sb_if.drain_req = 1'b0;
    @(negedge clk);
    cyc("rst0", 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // RAW with writeback bypass
    dec(1, 0, 0, 5, 1, 1);  cyc("raw_issue", 1, 0, 1, 0, 0);
    dec(1, 5, 0, 6, 1, 0);  cyc("raw_stall0", 0, 1, 1, 0, 0);
                            cyc("raw_stall1", 0, 1, 1, 0, 0);
    wb(1, 5);               cyc("raw_bypass", 1, 0, 0, 0, 0);
    wb(0, 0);

    // WAW and x0
    dec(1, 0, 0, 7, 1, 1);  cyc("waw_long", 1, 0, 1, 0, 0);
    dec(1, 0, 0, 7, 1, 0);  cyc("waw_stall", 0, 1, 1, 0, 0);
    dec(1, 0, 0, 0, 1, 0);  cyc("x0_plain", 1, 0, 1, 0, 0);
    dec(1, 0, 0, 0, 1, 1);  cyc("x0_long", 1, 0, 1, 0, 0);
    dec(0, 0, 0, 0, 0, 0); wb(1, 7); cyc("waw_wb", 0, 0, 0, 0, 0);
    wb(0, 0);

    // Outstanding limit
    dec(1, 0, 0, 1, 1, 1);  cyc("lim_x1", 1, 0, 1, 0, 0);
    dec(1, 0, 0, 2, 1, 1);  cyc("lim_x2", 1, 0, 2, 0, 0);
    dec(1, 0, 0, 3, 1, 1);  cyc("lim_stall", 0, 1, 2, 0, 0);
    wb(1, 1);               cyc("lim_wb_issue", 1, 0, 2, 0, 0);
    wb(0, 0);
    dec(1, 1, 0, 8, 1, 0);  cyc("lim_x1_free", 1, 0, 2, 0, 0);
    dec(1, 2, 0, 8, 1, 0);  cyc("lim_x2_busy", 0, 1, 2, 0, 0);
    dec(1, 0, 3, 8, 1, 0);  cyc("lim_x3_busy", 0, 1, 2, 0, 0);
    dec(0, 0, 0, 0, 0, 0); wb(1, 2); cyc("lim_wb2", 0, 0, 1, 0, 0);
    wb(1, 3);               cyc("lim_wb3", 0, 0, 0, 0, 0);
    wb(0, 0);

    // Set/clear collision on one register
    dec(1, 0, 0, 4, 1, 1);  cyc("col_set", 1, 0, 1, 0, 0);
    wb(1, 4);               cyc("col_both", 1, 0, 1, 0, 0);
    wb(0, 0);
    dec(1, 4, 0, 0, 0, 0);  cyc("col_still_busy", 0, 1, 1, 0, 0);
    dec(0, 0, 0, 0, 0, 0); wb(1, 4); cyc("col_wb", 0, 0, 0, 0, 0);
    wb(0, 0);

    // Flush suppresses issue without stall
    dec(1, 0, 0, 11, 1, 1); sb_if.flush = 1'b1; cyc("flush", 0, 0, 0, 0, 0);
    sb_if.flush = 1'b0;

    // Drain with pending ops
    dec(1, 0, 0, 1, 1, 1);  cyc("dr_x1", 1, 0, 1, 0, 0);
    dec(1, 0, 0, 2, 1, 1);  cyc("dr_x2", 1, 0, 2, 0, 0);
    dec(0, 0, 0, 0, 0, 0); sb_if.drain_req = 1'b1; cyc("dr_req", 0, 0, 2, 0, 0);
    sb_if.drain_req = 1'b0;
    dec(1, 10, 0, 12, 1, 0); cyc("dr_block", 0, 1, 2, 0, 0);
    wb(1, 1);               cyc("dr_wb1", 0, 1, 1, 0, 0);
    wb(1, 2);               cyc("dr_wb2_ack", 0, 1, 0, 1, 0);
    wb(0, 0);               cyc("dr_run", 1, 0, 0, 0, 0);
    dec(0, 0, 0, 0, 0, 0); sb_if.drain_req = 1'b1; cyc("dr_zero_ack", 0, 0, 0, 1, 0);
    sb_if.drain_req = 1'b0; cyc("dr_ack_done", 0, 0, 0, 0, 0);

    // Error is sticky
    wb(1, 9);               cyc("err_set", 0, 0, 0, 0, 1);
    wb(0, 0);               cyc("err_hold", 0, 0, 0, 0, 1);
    wb(1, 0);               cyc("err_x0", 0, 0, 0, 0, 1);
    wb(0, 0);

    // Reset in the middle of a drain
    dec(1, 0, 0, 1, 1, 1);  cyc("rd_x1", 1, 0, 1, 0, 1);
    dec(0, 0, 0, 0, 0, 0); sb_if.drain_req = 1'b1; cyc("rd_req", 0, 0, 1, 0, 1);
    sb_if.drain_req = 1'b0;
    dec(1, 1, 0, 0, 0, 0); rst_n = 1'b0; cyc("rd_reset", 0, 1, 0, 0, 0);
    rst_n = 1'b1;           cyc("rd_run", 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/armleocpu_scoreboard.md
Name: armleocpu_scoreboard

Overview:
Register-hazard interlock controller between decode and execute. Tracks destination registers of issued long-latency operations (loads, mul/div, CSR reads) that have not yet written back. Gates decode-to-execute issue on RAW/WAW hazards and on an outstanding-operation limit. Provides a drain sequence that fences and serializing instructions use to wait until all outstanding operations have written back.

Parameters:
MAX_PENDING, 2, maximum outstanding long-latency ops in flight (1..7)
CNT_W, 3, width of pending_count; must hold MAX_PENDING

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
dec_valid  in  1  decode presents an instruction
dec_rs1_read  in  1  instruction reads rs1
dec_rs1_addr  in  5  rs1 index
dec_rs2_read  in  1  instruction reads rs2
dec_rs2_addr  in  5  rs2 index
dec_rd_write  in  1  instruction writes rd
dec_rd_addr  in  5  rd index
dec_long  in  1  result arrives later via writeback port
exe_ready  in  1  execute accepts this cycle
flush  in  1  pipeline kill; suppresses issue this cycle
issue_valid  out  1  instruction may be presented to execute
dec_stall  out  1  dec_valid held by hazard/limit/drain
wb_valid  in  1  long-latency result written back
wb_rd_addr  in  5  register written back
drain_req  in  1  request to wait for zero outstanding ops
drain_ack  out  1  one-cycle pulse: drain complete
pending_count  out  CNT_W  outstanding long ops
sb_error  out  1  sticky: writeback to non-busy register or count underflow/overflow

Behaviour:
- Reset (rst_n=0 at posedge): busy[31:1]=0, pending_count=0, state=RUN, drain_ack=0, sb_error=0. Reset takes priority over all other inputs, mid-drain included.
- x0 never busy; hazard compares with index 0 are ignored.
- clr_mask = wb_valid ? onehot(wb_rd_addr) : 0. eff_busy = busy & ~clr_mask (same-cycle writeback resolves the hazard; the regfile is write-through).
- hazard = (rs1_read & rs1!=0 & eff_busy[rs1]) | (rs2_read & rs2!=0 & eff_busy[rs2]) | (rd_write & rd!=0 & eff_busy[rd]).
- limit = dec_long & (pending_count - (wb_valid & busy[wb_rd]) == MAX_PENDING).
- issue_valid = dec_valid & ~hazard & ~limit & ~flush & (state==RUN). This is combinational. dec_stall = dec_valid & ~issue_valid & ~flush.
- fire = issue_valid & exe_ready. On fire with dec_long & rd_write & rd!=0: set busy[rd] and increment the count.
- wb_valid with busy[wb_rd] (pre-update): clear the bit and decrement the count. wb_valid to a non-busy register or to x0: no state change; sb_error<=1.
- Set and clear in the same cycle on the same register: set wins, count unchanged. Different registers: both apply, count unchanged.
- Count overflow or underflow (unreachable if the rules above hold) sets sb_error. sb_error clears only on reset.
- flush does not clear busy bits, because in-flight ops still write back.
- FSM, RUN -> DRAIN: drain_req=1 in RUN. If pending_count==0 that cycle, pulse drain_ack next cycle and stay RUN. drain_req is sampled only in RUN.
- FSM, DRAIN: issue blocked. When the next-state count is 0, drain_ack<=1 for one cycle and state<=RUN.
- drain_ack is registered, high exactly one cycle per request.

Test Plan:
- Reset, then decode rd=x5 long with exe_ready=1 -> busy[5]=1, pending_count=1. Next decode reads rs1=x5 -> dec_stall=1, issue_valid=0 until wb_valid wb_rd=5. In the wb cycle issue_valid=1 (bypass) and pending_count returns to 0.
- WAW: long to x7 pending; decode writes rd=x7 non-long -> stall. rs1=x0 or rd=x0 with x0 written -> never stalls, busy unchanged.
- Limit with MAX_PENDING=2: long ops to x1,x2 issued; third long to x3 -> stall. Same cycle wb x1 -> third issues, count stays 2, busy={x2,x3}.
- Set/clear collision: busy[4]=1; wb x4 with decode long rd=x4 firing -> busy[4]=1, count=1, no error.
- Drain: two pending; drain_req=1 -> state DRAIN, issue blocked. wb x1, then wb x2 -> drain_ack high exactly one cycle after the second wb, then RUN. drain_req with count=0 -> ack next cycle.
- Error/reset: wb x9 not busy -> sb_error=1 and stays 1. Assert rst_n=0 mid-DRAIN -> all outputs zero, state RUN next cycle.
